// File: rtl/trade_hist_pkg.sv
// rtl/trade_hist_pkg.sv - shared widths, entry layout and scan states for the trade history buffer
package trade_hist_pkg;

  localparam int PRICE_W    = 8;
  localparam int SPREAD_W   = 8;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  // Price occupies bits [15:8], spread bits [7:0].
  typedef struct packed {
    logic [PRICE_W-1:0]  price;
    logic [SPREAD_W-1:0] spread;
  } entry_t;

endpackage

// File: rtl/match_edge_detect.sv
// rtl/match_edge_detect.sv - rising-edge detector for the matching engine trade level
module match_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_d;

  always_ff @(posedge clk) begin
    if (reset) in_d <= 1'b0;
    else       in_d <= in;
  end

  assign rise = in & ~in_d;

endmodule

// File: rtl/trade_history_buffer.sv
// rtl/trade_history_buffer.sv - trade ring buffer with registered history read and windowed min/max scan
module trade_history_buffer
  import trade_hist_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                match_signal,
  input  logic [PRICE_W-1:0]  trade_price,
  input  logic [SPREAD_W-1:0] spread,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   rd_idx,
  output logic [PRICE_W-1:0]  rd_price,
  output logic [SPREAD_W-1:0] rd_spread,
  output logic                rd_valid,
  output logic [ADDR_W:0]     count,
  output logic [PRICE_W-1:0]  last_price,
  output logic [PRICE_W-1:0]  win_min,
  output logic [PRICE_W-1:0]  win_max,
  output logic                stats_update,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);

  logic                match_rise;
  logic                wr_en;
  entry_t              mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   scan_idx;
  logic [ADDR_W-1:0]   scan_addr;
  logic [ADDR_W:0]     count_m1;
  logic [PRICE_W-1:0]  scan_price;
  logic [PRICE_W-1:0]  acc_min;
  logic [PRICE_W-1:0]  acc_max;
  logic                scan_last;
  logic                commit;
  scan_state_t         state;
  scan_state_t         state_next;

  match_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .in    (match_signal),
    .rise  (match_rise)
  );

  assign wr_en = match_rise & ~freeze;

  // Storage is left unreset; count masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {trade_price, spread};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      count      <= '0;
      last_price <= '0;
    end else if (wr_en) begin
      wr_ptr     <= wr_ptr + PTR_ONE;
      last_price <= trade_price;
      if (count != FULL) count <= count + CNT_ONE;
    end
  end

  assign rd_addr = wr_ptr - PTR_ONE - rd_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_price  <= '0;
      rd_spread <= '0;
      rd_valid  <= 1'b0;
    end else if ({1'b0, rd_idx} < count) begin
      rd_price  <= mem[rd_addr].price;
      rd_spread <= mem[rd_addr].spread;
      rd_valid  <= 1'b1;
    end else begin
      rd_price  <= '0;
      rd_spread <= '0;
      rd_valid  <= 1'b0;
    end
  end

  // Scan walks newest to oldest through the same index mapping as the read port.
  assign scan_addr  = wr_ptr - PTR_ONE - scan_idx;
  assign scan_price = mem[scan_addr].price;
  assign count_m1   = count - CNT_ONE;
  assign scan_last  = ({1'b0, scan_idx} == count_m1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    if (wr_en) begin
      state_next = ST_SCAN;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_IDLE;
        ST_SCAN: if (scan_last) state_next = ST_DONE;
        ST_DONE: begin
          state_next = ST_IDLE;
          commit     = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx     <= '0;
      acc_min      <= '1;
      acc_max      <= '0;
      win_min      <= '0;
      win_max      <= '0;
      stats_update <= 1'b0;
    end else begin
      stats_update <= 1'b0;
      if (wr_en) begin
        scan_idx <= '0;
        acc_min  <= '1;
        acc_max  <= '0;
      end else if (state == ST_SCAN) begin
        if (scan_price < acc_min) acc_min <= scan_price;
        if (scan_price > acc_max) acc_max <= scan_price;
        if (!scan_last) scan_idx <= scan_idx + PTR_ONE;
      end
      if (commit) begin
        win_min      <= acc_min;
        win_max      <= acc_max;
        stats_update <= 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/trade_history_buffer.md
# trade_history_buffer

Ring buffer that records every executed trade (price and spread) from the matching engine and serves that history to the VGA trend display. It sits directly downstream of the matching engine and spread calculator, and directly upstream of the trend display. It also maintains a windowed minimum and maximum price so the display can auto-scale its vertical axis. Writes are triggered on the rising edge of `match_signal`; a scan FSM recomputes the statistics after every write.

## Interface

Parameters:
- `DEPTH`, 64: number of history entries; must be a power of two, 4..256.
- `ADDR_W`, log2(`DEPTH`): pointer and index width.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock (`CLOCK_50`). This is the block's only clock.
- `reset`  in  1  synchronous reset, active-high.
- `match_signal`  in  1  trade-executed level from the matching engine.
- `trade_price`  in  8  executed price; sampled on the write edge.
- `spread`  in  8  current spread; sampled on the write edge.
- `freeze`  in  1  while high, new trades are ignored (connected to the halt signal).
- `rd_idx`  in  ADDR_W  history index; 0 is the newest entry.
- `rd_price`  out  8  registered price at `rd_idx`.
- `rd_spread`  out  8  registered spread at `rd_idx`.
- `rd_valid`  out  1  registered; high when `rd_idx` < `count`.
- `count`  out  ADDR_W+1  number of valid entries; saturates at `DEPTH`.
- `last_price`  out  8  price of the newest entry.
- `win_min`  out  8  minimum price over all valid entries.
- `win_max`  out  8  maximum price over all valid entries.
- `stats_update`  out  1  one-cycle pulse when `win_min`/`win_max` are refreshed.
- `busy`  out  1  high while the scan FSM is not IDLE.

## Operation

- **Edge detect.** `match_d` is `match_signal` delayed by one cycle. A write is `wr_en = match_signal & ~match_d & ~freeze`.
- **Write.** On `wr_en`, `mem[wr_ptr] <= {trade_price, spread}`, `wr_ptr <= wr_ptr + 1` (wraps modulo `DEPTH`), and `count` increments unless it already equals `DEPTH`. `last_price <= trade_price`.
- **Overflow.** When full, a write overwrites the oldest entry and `count` stays at `DEPTH`.
- **Read.** Address is `(wr_ptr - 1 - rd_idx) mod DEPTH`. If `rd_idx >= count`, then `rd_valid = 0` and `rd_price = rd_spread = 0`.
- **Scan FSM.** States are IDLE, SCAN and DONE.
  - Any state goes to SCAN on `wr_en`. Entering SCAN sets `scan_idx = 0`, `acc_min = 8'hFF`, `acc_max = 8'h00`.
  - In SCAN, each cycle folds the entry at history index `scan_idx` into `acc_min`/`acc_max`, using the post-write pointer and count. When `scan_idx == count - 1`, the FSM moves to DONE; otherwise `scan_idx` increments.
  - DONE sets `win_min <= acc_min`, `win_max <= acc_max`, pulses `stats_update`, and returns to IDLE.
- **Write during SCAN or DONE.** The write is accepted and the scan restarts from index 0. In that case DONE's update and pulse are suppressed.
- **Unsigned compare.** Prices are unsigned 8-bit values. Equal values leave the accumulator unchanged.
- **Freeze.** Writes are blocked, but an in-flight scan completes and reads continue.

## Timing

- **Reset.** The following are all 0: `wr_ptr`, `count`, `last_price`, `win_min`, `win_max`, `stats_update`, `rd_price`, `rd_spread`, `rd_valid`, `match_d`, `busy`. The FSM is in IDLE. Memory contents are don't-care, because `count = 0` masks them.
- **Reset mid-scan.** Reset overrides everything in the same edge.
- **Write latency.** `match_signal` rises before edge E0; the write commits at E0.
  - `count` and `last_price` are visible after E0.
  - A read of `rd_idx = 0` issued after E0 returns the new entry after E1.
- **Read latency.** One cycle from `rd_idx` to `rd_price`/`rd_spread`/`rd_valid`.
- **Scan latency.** SCAN occupies edges E1..E`count`; DONE is at edge E`count`+1, where `win_*` update and `stats_update` is high for the following cycle. Total latency is `count` + 1 cycles after the write edge; the maximum is `DEPTH` + 1.
- **Held level.** A `match_signal` held high for N cycles produces exactly one write.
- **Re-arm.** Two pulses separated by one low cycle produce two writes.

## Structure

- **Shared package `trade_hist_pkg`.** Holds `PRICE_W = 8`, the default `DEPTH`/`ADDR_W`, the scan state encoding (IDLE=0, SCAN=1, DONE=2), and the entry layout (price in bits [15:8], spread in bits [7:0]).
- **Sub-module `match_edge_detect`.** Ports are `clk`, `reset`, `in`, `rise`. It registers the input and outputs `in & ~in_d`. The qualification by `freeze` stays in the parent.
- **Storage.** Register array, so the read port and the scan port can access it independently in the same cycle.

## Test plan

- **Basic write.** After reset, pulse `match_signal` with price 0x40, spread 0x05 → `count` = 1, `last_price` = 0x40; `rd_idx` = 0 gives 0x40/0x05 with `rd_valid` = 1 one cycle later; `rd_idx` = 1 gives `rd_valid` = 0 and price 0; `stats_update` fires 2 cycles after the write with `win_min` = `win_max` = 0x40.
- **Statistics over a sequence.** Write prices 0x30, 0x10, 0x7F, 0x20 → `win_min` = 0x10, `win_max` = 0x7F; `rd_idx` 0..3 reads 0x20, 0x7F, 0x10, 0x30.
- **Overflow.** With `DEPTH` = 4, write 0x01..0x06 → `count` = 4; history reads 0x06, 0x05, 0x04, 0x03; `win_min` = 0x03.
- **Write during scan.** With 60 entries valid and a scan in progress, a new write mid-scan → no `stats_update` from the aborted scan; exactly one pulse arrives 62 cycles after the second write, and it includes the new entry.
- **Edge behaviour and freeze.** Hold `match_signal` high for 10 cycles → 1 write. Assert `freeze` and pulse `match_signal` → `count` unchanged. Deassert `freeze` and pulse → write accepted.
- **Reset mid-scan.** Assert `reset` during SCAN → next cycle all outputs are 0, `busy` = 0, and no `stats_update` pulse occurs.
